mux_n_reg: RTL and testbench

MUX_N_REG -- requirements
Module: mux_n_reg

---
 rtl/mux_n_reg.sv | 83 ++++++++
 tb/tb_mux_n_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N-way channel select behind a one-deep valid/ready stage.
// Out-of-range selects still complete as a zero beat and raise a sticky error flag.
module mux_n_reg #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  input  logic                 err_clr
);

  localparam logic [SEL_W:0] LP_N = (SEL_W + 1)'(N);

  logic             w_in_ready;
  logic             w_accept;
  logic             w_consume;
  logic             w_sel_ok;
  logic [N-1:0]     w_sel_dec;
  logic [WIDTH-1:0] w_mux;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_dout;
  logic             r_sel_err;

  // When N is a power of two every select value is in range, so this folds to 1.
  assign w_sel_ok   = ({1'b0, sel} < LP_N);
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_consume  = r_out_valid && out_ready;

  // One-hot AND-OR mux: unselected channels are masked to zero, so X never leaks into dout.
  always_comb begin
    w_sel_dec = '0;
    w_mux     = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_dec[k] = 1'b1;
      end else begin
        w_sel_dec[k] = 1'b0;
      end
      w_mux = w_mux | (din[k*WIDTH +: WIDTH] & {WIDTH{w_sel_dec[k]}});
    end
  end

  // Output stage: load on accept, drop valid on a consume without a new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_dout      <= w_mux;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky select error; a new out-of-range accept wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed-vector bench for mux_n_reg: N=4/W=64 handshake table, N=3 select-error
// sequence, asynchronous reset mid-hold, and an N=2 randomised scoreboard run.
module tb_mux_n_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- N=4, WIDTH=64 ----------------
  logic [255:0] din4;
  logic [1:0]   sel4 = 2'd0;
  logic         iv4 = 1'b0, ordy4 = 1'b1, clr4 = 1'b0;
  logic         rdy4, ov4, err4;
  logic [63:0]  dout4;

  mux_n_reg #(.WIDTH(64), .N(4), .SEL_W(2)) u4 (
    .clk(clk), .rst(rst), .din(din4), .sel(sel4), .in_valid(iv4), .in_ready(rdy4),
    .dout(dout4), .out_valid(ov4), .out_ready(ordy4), .sel_err(err4), .err_clr(clr4)
  );

  // ---------------- N=3, WIDTH=8 ----------------
  logic [23:0] din3 = {8'h33, 8'h22, 8'h11};
  logic [1:0]  sel3 = 2'd0;
  logic        iv3 = 1'b0, ordy3 = 1'b1, clr3 = 1'b0;
  logic        rdy3, ov3, err3;
  logic [7:0]  dout3;

  mux_n_reg #(.WIDTH(8), .N(3), .SEL_W(2)) u3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel3), .in_valid(iv3), .in_ready(rdy3),
    .dout(dout3), .out_valid(ov3), .out_ready(ordy3), .sel_err(err3), .err_clr(clr3)
  );

  // ---------------- N=2, WIDTH=16 ----------------
  logic [31:0] din2 = 32'h0;
  logic        sel2 = 1'b0;
  logic        iv2 = 1'b0, ordy2 = 1'b1, clr2 = 1'b0;
  logic        rdy2, ov2, err2;
  logic [15:0] dout2;

  mux_n_reg #(.WIDTH(16), .N(2), .SEL_W(1)) u2 (
    .clk(clk), .rst(rst), .din(din2), .sel(sel2), .in_valid(iv2), .in_ready(rdy2),
    .dout(dout2), .out_valid(ov2), .out_ready(ordy2), .sel_err(err2), .err_clr(clr2)
  );

  localparam logic [63:0] C1 = 64'h1111111111111111;
  localparam logic [63:0] C2 = 64'h2222222222222222;
  localparam logic [63:0] C3 = 64'h3333333333333333;
  localparam logic [63:0] C4 = 64'h4444444444444444;
  localparam logic [63:0] CA = 64'hAAAAAAAAAAAAAAAA;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        alt;       // drive junk on all channels
    logic        exp_rdy;   // in_ready before the edge
    logic        exp_ov;    // out_valid after the edge
    logic [63:0] exp_dout;  // dout after the edge
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic        m_ov;
    logic        m_rdy;
    logic [15:0] q[$];
    logic [15:0] exp2;
    int          r;

    vecs[0]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, C3};  // single beat, sel=2
    vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, C1};  // streaming 0..3
    vecs[2]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, C2};
    vecs[3]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, C3};
    vecs[4]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, C4};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, C4};  // consume, dout holds
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, C4};  // idle
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, C2};  // accept sel=1, then stall
    vecs[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, C2};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, C2};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, C2};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, C2};  // release: ready same cycle
    vecs[12] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, C1};
    vecs[13] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, C2};  // accept + consume, no bubble
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, C2};

    din4 = {C4, C3, C2, C1};

    // Reset state
    #2;
    chk("rst_ov4", {63'd0, ov4}, 64'd0);
    chk("rst_dout4", dout4, 64'd0);
    chk("rst_err4", {63'd0, err4}, 64'd0);
    chk("rst_rdy4", {63'd0, rdy4}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven handshake vectors on the N=4 instance
    for (int i = 0; i < 15; i++) begin
      iv4   = vecs[i].iv;
      sel4  = vecs[i].sel;
      ordy4 = vecs[i].ordy;
      din4  = vecs[i].alt ? {CA, CA, CA, CA} : {C4, C3, C2, C1};
      #1;
      chk($sformatf("v%0d_rdy", i), {63'd0, rdy4}, {63'd0, vecs[i].exp_rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), {63'd0, ov4}, {63'd0, vecs[i].exp_ov});
      chk($sformatf("v%0d_dout", i), dout4, vecs[i].exp_dout);
      chk($sformatf("v%0d_err", i), {63'd0, err4}, 64'd0);
    end
    iv4 = 1'b0; ordy4 = 1'b1; din4 = {C4, C3, C2, C1};

    // N=3 out-of-range select and sticky error
    iv3 = 1'b1; sel3 = 2'd2;
    @(posedge clk); #1;
    chk("n3_sel2_dout", {56'd0, dout3}, 64'h33);
    chk("n3_sel2_err", {63'd0, err3}, 64'd0);
    sel3 = 2'd3;
    @(posedge clk); #1;
    chk("n3_sel3_dout", {56'd0, dout3}, 64'h00);
    chk("n3_sel3_ov", {63'd0, ov3}, 64'd1);
    chk("n3_sel3_err", {63'd0, err3}, 64'd1);
    iv3 = 1'b0;
    @(posedge clk); #1;
    chk("n3_sticky_err", {63'd0, err3}, 64'd1);
    chk("n3_idle_ov", {63'd0, ov3}, 64'd0);
    clr3 = 1'b1;
    @(posedge clk); #1;
    chk("n3_clr_err", {63'd0, err3}, 64'd0);
    iv3 = 1'b1; sel3 = 2'd3;
    @(posedge clk); #1;
    chk("n3_setwins_err", {63'd0, err3}, 64'd1);
    chk("n3_setwins_dout", {56'd0, dout3}, 64'h00);
    clr3 = 1'b0; sel3 = 2'd1;
    @(posedge clk); #1;
    chk("n3_sel1_dout", {56'd0, dout3}, 64'h22);
    chk("n3_sel1_err", {63'd0, err3}, 64'd1);
    iv3 = 1'b0;

    // Asynchronous reset while a beat is held
    iv4 = 1'b1; sel4 = 2'd3; ordy4 = 1'b0;
    @(posedge clk); #1;
    chk("hold_ov", {63'd0, ov4}, 64'd1);
    chk("hold_dout", dout4, C4);
    sel4 = 2'd1;
    #3; rst = 1'b1; #1;
    chk("arst_ov", {63'd0, ov4}, 64'd0);
    chk("arst_dout", dout4, 64'd0);
    chk("arst_err4", {63'd0, err4}, 64'd0);
    chk("arst_err3", {63'd0, err3}, 64'd0);
    chk("arst_rdy", {63'd0, rdy4}, 64'd1);
    @(posedge clk); #1;
    chk("inrst_noacc_ov", {63'd0, ov4}, 64'd0);
    chk("inrst_noacc_dout", dout4, 64'd0);
    #2; rst = 1'b0;
    sel4 = 2'd0; ordy4 = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ov", {63'd0, ov4}, 64'd1);
    chk("postrst_dout", dout4, C1);
    iv4 = 1'b0;
    @(posedge clk); #1;

    // N=2 randomised valid/ready with scoreboard
    m_ov = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      r     = $urandom;
      iv2   = r[0];
      ordy2 = r[1];
      sel2  = r[2];
      din2  = $urandom;
      #1;
      m_rdy = !m_ov || ordy2;
      chk("rnd_rdy", {63'd0, rdy2}, {63'd0, m_rdy});
      if (m_ov && ordy2) begin
        chk("rnd_dout", {48'd0, dout2}, {48'd0, q[0]});
        void'(q.pop_front());
      end
      if (iv2 && m_rdy) begin
        exp2 = sel2 ? din2[31:16] : din2[15:0];
        q.push_back(exp2);
      end
      @(posedge clk); #1;
      m_ov = (q.size() != 0);
      chk("rnd_ov", {63'd0, ov2}, {63'd0, m_ov});
    end
    iv2 = 1'b0;
    chk("rnd_err", {63'd0, err2}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
